alu_scheduler: RTL and testbench

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_scheduler_pkg.sv | 18 +
 rtl/alu_rr_arbiter.sv | 20 ++
 rtl/alu_scheduler.sv | 133 +++++++++++++
 tb/tb_alu_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_scheduler_pkg.sv
// Shared types and constants for the ALU scheduler: FSM states,
// ALU opcode encodings and the default operand width.
package alu_scheduler_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way round-robin grant: a lone requester always wins, and on a tie
// the requester named by prio wins. Purely combinational.
module alu_rr_arbiter (
   input  logic [1:0] valid,
   input  logic       prio,
   output logic [1:0] grant
);

   // Resolve the one-hot grant from the request vector and tie-break pointer
   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = prio ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between two requesters. Each accepted
// request runs IDLE -> EXEC -> RESP; the ALU is driven from the operand
// registers and its result is latched at the end of EXEC.
module alu_scheduler
   import alu_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,

   input  logic                  req0_valid_i,
   output logic                  req0_ready_o,
   input  logic [DATA_WIDTH-1:0] req0_a_i,
   input  logic [DATA_WIDTH-1:0] req0_b_i,
   input  logic [1:0]            req0_op_i,
   output logic                  rsp0_valid_o,
   input  logic                  rsp0_ready_i,
   output logic [DATA_WIDTH-1:0] rsp0_data_o,
   output logic                  rsp0_zero_o,
   output logic                  rsp0_neg_o,

   input  logic                  req1_valid_i,
   output logic                  req1_ready_o,
   input  logic [DATA_WIDTH-1:0] req1_a_i,
   input  logic [DATA_WIDTH-1:0] req1_b_i,
   input  logic [1:0]            req1_op_i,
   output logic                  rsp1_valid_o,
   input  logic                  rsp1_ready_i,
   output logic [DATA_WIDTH-1:0] rsp1_data_o,
   output logic                  rsp1_zero_o,
   output logic                  rsp1_neg_o,

   output logic [DATA_WIDTH-1:0] alu_a_o,
   output logic [DATA_WIDTH-1:0] alu_b_o,
   output logic [1:0]            alu_op_o,
   input  logic [DATA_WIDTH-1:0] alu_data_i,
   input  logic                  alu_zero_i,
   input  logic                  alu_neg_i,

   output logic                  busy_o,
   output logic                  owner_o
);

   state_t                state_q;
   logic                  prio_q;
   logic                  owner_q;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [1:0]            op_q;
   logic [DATA_WIDTH-1:0] res_q;
   logic                  zero_q;
   logic                  neg_q;

   logic [1:0]            grant;
   logic                  in_idle;
   logic                  accept;
   logic                  gnt_idx;
   logic                  owner_rsp_ready;

   alu_rr_arbiter u_arb (
      .valid (/*req*/{req1_valid_i, req0_valid_i}),
      .prio  (prio_q),
      .grant (grant)
   );

   assign in_idle         = (state_q == IDLE);
   // The arbiter only grants a requester that is valid, so any grant in IDLE is an accept.
   assign accept          = in_idle && (grant != 2'b00);
   assign gnt_idx         = grant[1];
   assign owner_rsp_ready = owner_q ? rsp1_ready_i : rsp0_ready_i;

   // Sequence each request through accept, ALU execution and response handshake
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 2'b00;
         res_q   <= '0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q     <= gnt_idx ? req1_a_i  : req0_a_i;
                  b_q     <= gnt_idx ? req1_b_i  : req0_b_i;
                  op_q    <= gnt_idx ? req1_op_i : req0_op_i;
                  owner_q <= gnt_idx;
                  prio_q  <= ~gnt_idx;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               res_q   <= alu_data_i;
               zero_q  <= alu_zero_i;
               neg_q   <= alu_neg_i;
               state_q <= RESP;
            end
            RESP: begin
               if (owner_rsp_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req0_ready_o = in_idle && grant[0];
   assign req1_ready_o = in_idle && grant[1];

   assign rsp0_valid_o = (state_q == RESP) && !owner_q;
   assign rsp1_valid_o = (state_q == RESP) &&  owner_q;

   assign rsp0_data_o  = res_q;
   assign rsp0_zero_o  = zero_q;
   assign rsp0_neg_o   = neg_q;
   assign rsp1_data_o  = res_q;
   assign rsp1_zero_o  = zero_q;
   assign rsp1_neg_o   = neg_q;

   assign alu_a_o      = a_q;
   assign alu_b_o      = b_q;
   assign alu_op_o     = op_q;

   assign busy_o       = !in_idle;
   assign owner_o      = owner_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: directed scenarios followed by
// randomized traffic, checked against a transaction-level model.
module tb_alu_scheduler;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_neg;
   logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_neg;
   logic [W-1:0]  req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
   logic [1:0]    req0_op, req1_op, alu_op;
   logic [W-1:0]  alu_a, alu_b, alu_data;
   logic          alu_zero, alu_neg, busy, owner;

   int            checks   = 0;
   int            failures = 0;
   int            ptr;          // model: which requester wins a tie
   int            last_owner;
   logic [W-1:0]  last_data;

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_alu(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a | b;
      endcase
   endfunction

   // Combinational ALU attached to the scheduler
   assign alu_data = ref_alu(alu_a, alu_b, alu_op);
   assign alu_zero = (alu_data == '0);
   assign alu_neg  = alu_data[W-1];

   alu_scheduler #(.DATA_WIDTH(W)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
      .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_op_i(req0_op),
      .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
      .rsp0_data_o(rsp0_data), .rsp0_zero_o(rsp0_zero), .rsp0_neg_o(rsp0_neg),
      .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
      .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_op_i(req1_op),
      .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
      .rsp1_data_o(rsp1_data), .rsp1_zero_o(rsp1_zero), .rsp1_neg_o(rsp1_neg),
      .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
      .alu_data_i(alu_data), .alu_zero_i(alu_zero), .alu_neg_i(alu_neg),
      .busy_o(busy), .owner_o(owner)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
      tick();
      chk("rst_busy",   busy, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_rsp0v",  rsp0_valid, 0);
      chk("rst_rsp1v",  rsp1_valid, 0);
      chk("rst_alu_a",  alu_a, 0);
      chk("rst_alu_b",  alu_b, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_owner",  owner, 0);
      chk("rst_data",   rsp0_data, 0);
      rst_n = 1'b1;
      ptr = 0;
   endtask

   // Runs one transaction from IDLE using the currently driven requests.
   // hold = cycles the owner withholds rsp ready; scramble = change inputs after accept.
   task automatic run_one(input int hold, input bit scramble);
      int g;
      logic [W-1:0] ea, eb, ed;
      logic [1:0]   eo;
      #1;
      if (!req0_valid && !req1_valid) g = -1;
      else if (req0_valid && req1_valid) g = ptr;
      else g = req1_valid ? 1 : 0;
      chk("grant_ready0", req0_ready, g == 0);
      chk("grant_ready1", req1_ready, g == 1);
      if (g < 0) begin
         tick();
         chk("idle_busy", busy, 0);
         return;
      end
      ea = g ? req1_a  : req0_a;
      eb = g ? req1_b  : req0_b;
      eo = g ? req1_op : req0_op;
      ed = ref_alu(ea, eb, eo);
      tick();
      ptr = 1 - g;
      chk("exec_busy",  busy, 1);
      chk("exec_owner", owner, g);
      chk("exec_alu_a", alu_a, ea);
      chk("exec_alu_b", alu_b, eb);
      chk("exec_op",    alu_op, eo);
      chk("exec_rsp0v", rsp0_valid, 0);
      chk("exec_rsp1v", rsp1_valid, 0);
      chk("exec_rdy",   {req0_ready, req1_ready}, 0);
      if (scramble) begin
         req0_a = $urandom; req0_b = $urandom; req0_op = 2'($urandom);
         req1_a = $urandom; req1_b = $urandom; req1_op = 2'($urandom);
      end
      // Non-owner ready is asserted to show it is ignored.
      rsp0_ready = (g == 1);
      rsp1_ready = (g == 0) ? 1'b0 : 1'b0;
      if (g == 0) rsp1_ready = 1'b1;
      tick();
      for (int i = 0; i <= hold; i++) begin
         if (i == hold) begin
            if (g == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
         end
         #1;
         chk("resp_valid_own", g ? rsp1_valid : rsp0_valid, 1);
         chk("resp_valid_oth", g ? rsp0_valid : rsp1_valid, 0);
         chk("resp_data0", rsp0_data, ed);
         chk("resp_data1", rsp1_data, ed);
         chk("resp_zero",  g ? rsp1_zero : rsp0_zero, ed == 0);
         chk("resp_neg",   g ? rsp1_neg  : rsp0_neg,  ed[W-1]);
         chk("resp_rdy",   {req0_ready, req1_ready}, 0);
         if (i < hold) tick();
      end
      tick();
      chk("done_busy", busy, 0);
      rsp0_ready = 0; rsp1_ready = 0;
      last_data  = ed;
      last_owner = g;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
      do_reset();

      // Single ADD on requester 0
      req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 2'b00;
      run_one(0, 1'b0);
      req0_valid = 0;
      chk("add_data", last_data, 8);
      chk("add_owner", last_owner, 0);
      #1 chk("add_idle_busy", busy, 0);

      // Simultaneous requests: req0 first, then req1, pointer back to req0
      do_reset();
      req0_valid = 1; req0_a = 7; req0_b = 7; req0_op = 2'b01;
      req1_valid = 1; req1_a = 1; req1_b = 1; req1_op = 2'b00;
      run_one(0, 1'b0);
      chk("tie_first_owner", last_owner, 0);
      chk("tie_first_data", last_data, 0);
      req0_valid = 0;
      run_one(0, 1'b0);
      chk("tie_second_owner", last_owner, 1);
      chk("tie_second_data", last_data, 2);
      req0_valid = 1; req1_valid = 1;
      #1 chk("tie_ptr_back", {req1_ready, req0_ready}, 2'b01);

      // Continuous contention alternates grants
      do_reset();
      req0_valid = 1; req1_valid = 1;
      for (int i = 0; i < 6; i++) begin
         run_one(i % 3, 1'b1);
         chk("alternate_owner", last_owner, i % 2);
      end
      req0_valid = 0; req1_valid = 0;

      // Held response with negative result; req0 waits meanwhile
      do_reset();
      req1_valid = 1; req1_a = 2; req1_b = 5; req1_op = 2'b01;
      run_one(4, 1'b0);
      chk("neg_data", last_data, 32'hFFFF_FFFD);
      req1_valid = 0;
      req0_valid = 1;
      #1 chk("neg_after_ready0", req0_ready, 1);
      req0_valid = 0;

      // Dropping valid before accept leaves no trace
      do_reset();
      req1_valid = 1; #2; req1_valid = 0;
      tick();
      chk("drop_busy", busy, 0);

      // Reset during EXEC aborts the request
      req0_valid = 1; req0_a = 9; req0_b = 4; req0_op = 2'b00;
      req1_valid = 1;
      tick();
      chk("abort_exec_busy", busy, 1);
      req0_valid = 0; req1_valid = 0;
      rst_n = 0;
      tick();
      rst_n = 1;
      ptr = 0;
      chk("abort_busy", busy, 0);
      chk("abort_alu_a", alu_a, 0);
      for (int i = 0; i < 3; i++) begin
         chk("abort_no_rsp", {rsp0_valid, rsp1_valid}, 0);
         tick();
      end
      req0_valid = 1; req1_valid = 1;
      run_one(0, 1'b0);
      chk("abort_next_owner", last_owner, 0);
      req0_valid = 0; req1_valid = 0;

      // Operand change right after accept does not disturb the result
      req0_valid = 1; req0_a = 10; req0_b = 20; req0_op = 2'b00;
      run_one(1, 1'b1);
      req0_valid = 0;
      chk("late_change_data", last_data, 30);

      // Randomized traffic
      do_reset();
      for (int n = 0; n < 40; n++) begin
         req0_valid = 1'($urandom); req1_valid = 1'($urandom);
         req0_a = $urandom; req0_b = $urandom; req0_op = 2'($urandom);
         req1_a = $urandom; req1_b = $urandom; req1_op = 2'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            req0_a = 32'h0000_0010; req0_b = 32'h0000_0010;
            req1_a = 32'h0000_0001; req1_b = 32'h0000_0002;
         end
         run_one($urandom_range(0, 3), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
